// File: rtl/control_unit_pkg.sv
// Shared types and encodings for the multicycle RV64I control unit.
package control_pkg;

    // FSM states, one per microstep of the multicycle sequence.
    typedef enum logic [4:0] {
        FETCH,
        FETCH2,
        DECODE,
        EX_R,
        EX_I,
        EX_LUI,
        ALU_WB,
        ADDR,
        MEM_RD,
        MEM_WAIT,
        LD_WB,
        ST,
        BRANCH,
        BR_NT,
        JALR_ADDR,
        JAL_LINK,
        JAL_JUMP,
        HALT
    } state_t;

    // ALU operation selector driven to the datapath.
    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_AND    = 4'd2,
        ALU_OR     = 4'd3,
        ALU_XOR    = 4'd4,
        ALU_SLL    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_SLT    = 4'd8,
        ALU_PASS_B = 4'd9
    } alu_op_t;

    // Major opcodes of the supported subset.
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    // Load/store width splice encodings (match funct3[1:0]).
    localparam logic [1:0] SPLICE_BYTE   = 2'd0;
    localparam logic [1:0] SPLICE_HALF   = 2'd1;
    localparam logic [1:0] SPLICE_WORD   = 2'd2;
    localparam logic [1:0] SPLICE_DOUBLE = 2'd3;

    // ALU B-operand mux selects.
    localparam logic [1:0] SRC_B_REG      = 2'd0;
    localparam logic [1:0] SRC_B_FOUR     = 2'd1;
    localparam logic [1:0] SRC_B_IMM      = 2'd2;
    localparam logic [1:0] SRC_B_IMM_SHL2 = 2'd3;

    // Register-file write-back source selects.
    localparam logic [1:0] WB_ALUOUT = 2'd0;
    localparam logic [1:0] WB_LOAD   = 2'd1;
    localparam logic [1:0] WB_PC     = 2'd2;

    // Every registered control flag the FSM drives.
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       pc_source;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        alu_op_t    alu_op;
        logic       load_aout;
        logic       reg_write;
        logic       load_reg_a;
        logic       load_reg_b;
        logic       load_mdr;
        logic       imem_read;
        logic       ir_write;
        logic [1:0] mem_to_reg;
        logic       dmem_op;
        logic [1:0] load_splice;
        logic [1:0] store_splice;
        logic       halted;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;

    // Branch funct3 values this control unit can evaluate.
    function automatic logic branch_legal(input logic [2:0] funct3);
        return (funct3 == 3'b000) || (funct3 == 3'b001) ||
               (funct3 == 3'b100) || (funct3 == 3'b101);
    endfunction

    // Branch outcome from the signed-compare ALU flags.
    function automatic logic branch_taken(input logic [2:0] funct3,
                                          input logic       equal,
                                          input logic       less);
        logic t;
        case (funct3)
            3'b000:  t = equal;
            3'b001:  t = !equal;
            3'b100:  t = less;
            3'b101:  t = !less;
            default: t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control/status bundle between the control unit and the RV64 datapath.
interface control_unit_if;
    import control_pkg::*;

    // Status from the datapath.
    logic [31:0] instruction;
    logic        alu_zero;
    logic        alu_equal;
    logic        alu_greater;
    logic        alu_less;

    // Control to the datapath.
    logic        PCWrite;
    logic        PCWriteCond;
    logic        PCWriteState;
    logic        PCSource;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB;
    alu_op_t     ALUOp;
    logic        LoadAOut;
    logic        RegWrite;
    logic        LoadRegA;
    logic        LoadRegB;
    logic        LoadMDR;
    logic        IMemRead;
    logic        IRWrite;
    logic [1:0]  MemToReg;
    logic        DMemOp;
    logic [1:0]  LoadSplice;
    logic [1:0]  StoreSplice;
    logic        halted;

    // Control unit side.
    modport master (
        input  instruction, alu_zero, alu_equal, alu_greater, alu_less,
        output PCWrite, PCWriteCond, PCWriteState, PCSource, ALUSrcA, ALUSrcB,
               ALUOp, LoadAOut, RegWrite, LoadRegA, LoadRegB, LoadMDR,
               IMemRead, IRWrite, MemToReg, DMemOp, LoadSplice, StoreSplice,
               halted
    );

    // Datapath side.
    modport slave (
        output instruction, alu_zero, alu_equal, alu_greater, alu_less,
        input  PCWrite, PCWriteCond, PCWriteState, PCSource, ALUSrcA, ALUSrcB,
               ALUOp, LoadAOut, RegWrite, LoadRegA, LoadRegB, LoadMDR,
               IMemRead, IRWrite, MemToReg, DMemOp, LoadSplice, StoreSplice,
               halted
    );

endinterface

// File: rtl/control_unit_alu_op_decoder.sv
// Maps opcode/funct3/funct7 of R- and I-type ALU instructions to an ALU op;
// flags encodings the datapath cannot execute so the FSM can halt.
module alu_op_decoder
    import control_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output alu_op_t    alu_op,
    output logic       illegal
);

    // Combinational op lookup; shift-immediates use funct7[6:1] since
    // RV64 shamt occupies bit 25.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        alu_op  = ALU_ADD;
        illegal = 1'b0;
        if (opcode == OPC_OP) begin
            case (funct3)
                3'b000: begin
                    if (funct7 == 7'b0000000)      alu_op = ALU_ADD;
                    else if (funct7 == 7'b0100000) alu_op = ALU_SUB;
                    else                           illegal = 1'b1;
                end
                3'b001: begin alu_op = ALU_SLL; illegal = (funct7 != 7'b0); end
                3'b010: begin alu_op = ALU_SLT; illegal = (funct7 != 7'b0); end
                3'b100: begin alu_op = ALU_XOR; illegal = (funct7 != 7'b0); end
                3'b101: begin
                    if (funct7 == 7'b0000000)      alu_op = ALU_SRL;
                    else if (funct7 == 7'b0100000) alu_op = ALU_SRA;
                    else                           illegal = 1'b1;
                end
                3'b110: begin alu_op = ALU_OR;  illegal = (funct7 != 7'b0); end
                3'b111: begin alu_op = ALU_AND; illegal = (funct7 != 7'b0); end
                default: illegal = 1'b1;
            endcase
        end else if (opcode == OPC_OP_IMM) begin
            case (funct3)
                3'b000: alu_op = ALU_ADD;
                3'b010: alu_op = ALU_SLT;
                3'b100: alu_op = ALU_XOR;
                3'b110: alu_op = ALU_OR;
                3'b111: alu_op = ALU_AND;
                3'b001: begin alu_op = ALU_SLL; illegal = (funct7[6:1] != 6'b0); end
                3'b101: begin
                    if (funct7[6:1] == 6'b000000)      alu_op = ALU_SRL;
                    else if (funct7[6:1] == 6'b010000) alu_op = ALU_SRA;
                    else                               illegal = 1'b1;
                end
                default: illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/control_unit.sv
// Multicycle control FSM for the RV64I datapath: sequences fetch, decode,
// execute, memory and write-back, and halts on ebreak/illegal encodings.
module control_unit
    import control_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    control_unit_if.master bus
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    alu_op_t    dec_op;
    logic       dec_illegal;
    logic       taken;
    logic       started;
    state_t     state;
    state_t     state_next;
    ctrl_t      ctrl_q;
    logic       unused_bits;

    assign opcode = bus.instruction[6:0];
    assign funct3 = bus.instruction[14:12];
    assign funct7 = bus.instruction[31:25];
    assign taken  = branch_taken(funct3, bus.alu_equal, bus.alu_less);

    // Register indices, immediates and the remaining flags belong to the datapath.
    assign unused_bits = ^{bus.alu_zero, bus.alu_greater,
                           bus.instruction[24:15], bus.instruction[11:7]};

    alu_op_decoder u_alu_op_decoder (
        .opcode  (opcode),
        .funct3  (funct3),
        .funct7  (funct7),
        .alu_op  (dec_op),
        .illegal (dec_illegal)
    );

    // Adds the shared "PC <= PC + 4" step to a control word.
    function automatic ctrl_t with_pc4(input ctrl_t c_in);
        ctrl_t c;
        c           = c_in;
        c.alu_src_a = 1'b0;
        c.alu_src_b = SRC_B_FOUR;
        c.alu_op    = ALU_ADD;
        c.pc_source = 1'b0;
        c.pc_write  = 1'b1;
        return c;
    endfunction

    // Moore control word for a state; flags not set here stay 0.
    function automatic ctrl_t decode_ctrl(input state_t     s,
                                          input alu_op_t    op,
                                          input logic [1:0] splice);
        ctrl_t c;
        c = CTRL_IDLE;
        case (s)
            FETCH:  c.imem_read = 1'b1;
            FETCH2: c.ir_write  = 1'b1;
            DECODE: begin
                c.load_reg_a = 1'b1;
                c.load_reg_b = 1'b1;
                c.alu_src_b  = SRC_B_IMM;
                c.load_aout  = 1'b1;
            end
            EX_R: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRC_B_REG;
                c.alu_op    = op;
                c.load_aout = 1'b1;
            end
            EX_I: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRC_B_IMM;
                c.alu_op    = op;
                c.load_aout = 1'b1;
            end
            EX_LUI: begin
                c.alu_src_b = SRC_B_IMM;
                c.alu_op    = ALU_PASS_B;
                c.load_aout = 1'b1;
            end
            ALU_WB: begin
                c            = with_pc4(c);
                c.reg_write  = 1'b1;
                c.mem_to_reg = WB_ALUOUT;
            end
            ADDR, JALR_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRC_B_IMM;
                c.load_aout = 1'b1;
            end
            MEM_WAIT: c.load_mdr = 1'b1;
            LD_WB: begin
                c             = with_pc4(c);
                c.reg_write   = 1'b1;
                c.mem_to_reg  = WB_LOAD;
                c.load_splice = splice;
            end
            ST: begin
                c              = with_pc4(c);
                c.dmem_op      = 1'b1;
                c.store_splice = splice;
            end
            BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_src_b     = SRC_B_REG;
                c.alu_op        = ALU_SUB;
                c.pc_write_cond = 1'b1;
                c.pc_source     = 1'b1;
            end
            BR_NT, JAL_LINK: c = with_pc4(c);
            JAL_JUMP: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = WB_PC;
                c.pc_source  = 1'b1;
                c.pc_write   = 1'b1;
            end
            HALT:    c.halted = 1'b1;
            default: c = CTRL_IDLE;
        endcase
        return c;
    endfunction

    // Next-state selection, including decode dispatch and branch resolution.
    always_comb begin
        state_next = state;
        case (state)
            FETCH:  state_next = FETCH2;
            FETCH2: state_next = DECODE;
            DECODE: begin
                case (opcode)
                    OPC_OP:     state_next = dec_illegal ? HALT : EX_R;
                    OPC_OP_IMM: state_next = dec_illegal ? HALT : EX_I;
                    OPC_LOAD,
                    OPC_STORE:  state_next = funct3[2] ? HALT : ADDR;
                    OPC_BRANCH: state_next = branch_legal(funct3) ? BRANCH : HALT;
                    OPC_JAL:    state_next = JAL_LINK;
                    OPC_JALR:   state_next = JALR_ADDR;
                    OPC_LUI:    state_next = EX_LUI;
                    default:    state_next = HALT;
                endcase
            end
            EX_R, EX_I, EX_LUI: state_next = ALU_WB;
            ADDR:      state_next = (opcode == OPC_LOAD) ? MEM_RD : ST;
            MEM_RD:    state_next = MEM_WAIT;
            MEM_WAIT:  state_next = LD_WB;
            BRANCH:    state_next = taken ? FETCH : BR_NT;
            JALR_ADDR: state_next = JAL_LINK;
            JAL_LINK:  state_next = JAL_JUMP;
            ALU_WB, LD_WB, ST, BR_NT, JAL_JUMP: state_next = FETCH;
            HALT:      state_next = HALT;
            default:   state_next = HALT;
        endcase
    end

    // State and registered control word; the first edge after reset only
    // presents the FETCH controls so reset itself keeps every flag low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state   <= FETCH;
            ctrl_q  <= CTRL_IDLE;
            started <= 1'b0;
        end else if (!started) begin
            started <= 1'b1;
            ctrl_q  <= decode_ctrl(FETCH, dec_op, funct3[1:0]);
        end else begin
            state  <= state_next;
            ctrl_q <= decode_ctrl(state_next, dec_op, funct3[1:0]);
        end
    end

    assign bus.PCWrite      = ctrl_q.pc_write;
    assign bus.PCWriteCond  = ctrl_q.pc_write_cond;
    assign bus.PCWriteState = ctrl_q.pc_write | (ctrl_q.pc_write_cond & taken);
    assign bus.PCSource     = ctrl_q.pc_source;
    assign bus.ALUSrcA      = ctrl_q.alu_src_a;
    assign bus.ALUSrcB      = ctrl_q.alu_src_b;
    assign bus.ALUOp        = ctrl_q.alu_op;
    assign bus.LoadAOut     = ctrl_q.load_aout;
    assign bus.RegWrite     = ctrl_q.reg_write;
    assign bus.LoadRegA     = ctrl_q.load_reg_a;
    assign bus.LoadRegB     = ctrl_q.load_reg_b;
    assign bus.LoadMDR      = ctrl_q.load_mdr;
    assign bus.IMemRead     = ctrl_q.imem_read;
    assign bus.IRWrite      = ctrl_q.ir_write;
    assign bus.MemToReg     = ctrl_q.mem_to_reg;
    assign bus.DMemOp       = ctrl_q.dmem_op;
    assign bus.LoadSplice   = ctrl_q.load_splice;
    assign bus.StoreSplice  = ctrl_q.store_splice;
    assign bus.halted       = ctrl_q.halted;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: directed instructions from the test plan
// followed by random instructions, each expanded by a per-instruction
// reference model into the expected per-cycle control words.
module tb_control_unit;
    import control_pkg::*;

    // Opcodes as written in the ISA manual.
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // Observable outputs, flattened into one comparable word.
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       pc_write_state;
        logic       pc_source;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_op;
        logic       load_aout;
        logic       reg_write;
        logic       load_reg_a;
        logic       load_reg_b;
        logic       load_mdr;
        logic       imem_read;
        logic       ir_write;
        logic [1:0] mem_to_reg;
        logic       dmem_op;
        logic [1:0] load_splice;
        logic [1:0] store_splice;
        logic       halted;
    } outs_t;

    typedef struct {
        outs_t       o;
        logic [31:0] ins;
        int          cyc;
    } sb_entry_t;

    logic      clk;
    logic      reset;
    int        n_tests;
    int        n_fail;
    sb_entry_t sb[$];
    outs_t     pending[$];
    bit        pending_halts;

    control_unit_if bus ();

    control_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic outs_t sample();
        outs_t o;
        o.pc_write       = bus.PCWrite;
        o.pc_write_cond  = bus.PCWriteCond;
        o.pc_write_state = bus.PCWriteState;
        o.pc_source      = bus.PCSource;
        o.alu_src_a      = bus.ALUSrcA;
        o.alu_src_b      = bus.ALUSrcB;
        o.alu_op         = bus.ALUOp;
        o.load_aout      = bus.LoadAOut;
        o.reg_write      = bus.RegWrite;
        o.load_reg_a     = bus.LoadRegA;
        o.load_reg_b     = bus.LoadRegB;
        o.load_mdr       = bus.LoadMDR;
        o.imem_read      = bus.IMemRead;
        o.ir_write       = bus.IRWrite;
        o.mem_to_reg     = bus.MemToReg;
        o.dmem_op        = bus.DMemOp;
        o.load_splice    = bus.LoadSplice;
        o.store_splice   = bus.StoreSplice;
        o.halted         = bus.halted;
        return o;
    endfunction

    // Mnemonic-level ALU semantics of an R/I instruction; returns 0 if unsupported.
    function automatic bit model_alu(input logic [31:0] ins, output logic [3:0] op);
        logic [2:0] f3;
        logic [6:0] f7;
        bit         is_r;
        f3   = ins[14:12];
        f7   = ins[31:25];
        is_r = (ins[6:0] == OP_R);
        op   = ALU_ADD;
        if (f3 == 3'b011) return 0;
        if (is_r && !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)))) return 0;
        if (!is_r && f3 == 3'b001 && ins[31:26] != 6'h00) return 0;
        if (!is_r && f3 == 3'b101 && ins[31:26] != 6'h00 && ins[31:26] != 6'h10) return 0;
        case (f3)
            3'b000: op = (is_r && f7 == 7'h20) ? ALU_SUB : ALU_ADD;
            3'b001: op = ALU_SLL;
            3'b010: op = ALU_SLT;
            3'b100: op = ALU_XOR;
            3'b101: op = ins[30] ? ALU_SRA : ALU_SRL;
            3'b110: op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return 1;
    endfunction

    function automatic outs_t pc4(input outs_t i);
        outs_t o;
        o                = i;
        o.alu_src_b      = 2'd1;
        o.pc_write       = 1'b1;
        o.pc_write_state = 1'b1;
        return o;
    endfunction

    // Expand one instruction into its expected cycle-by-cycle outputs.
    task automatic build(input logic [31:0] ins, input bit eq, input bit less, input int halt_cycles);
        outs_t      z;
        outs_t      o;
        logic [3:0] op;
        logic [2:0] f3;
        bit         legal;
        bit         tk;
        z  = '0;
        f3 = ins[14:12];
        pending.delete();
        pending_halts = 0;
        o = z; o.imem_read = 1; pending.push_back(o);
        o = z; o.ir_write = 1;  pending.push_back(o);
        o = z; o.load_reg_a = 1; o.load_reg_b = 1; o.alu_src_b = 2; o.load_aout = 1;
        pending.push_back(o);
        legal = 1;
        case (ins[6:0])
            OP_R, OP_I: begin
                legal = model_alu(ins, op);
                if (legal) begin
                    o = z; o.alu_src_a = 1; o.alu_src_b = (ins[6:0] == OP_I) ? 2'd2 : 2'd0;
                    o.alu_op = op; o.load_aout = 1; pending.push_back(o);
                    o = pc4(z); o.reg_write = 1; pending.push_back(o);
                end
            end
            OP_LUI: begin
                o = z; o.alu_src_b = 2; o.alu_op = ALU_PASS_B; o.load_aout = 1; pending.push_back(o);
                o = pc4(z); o.reg_write = 1; pending.push_back(o);
            end
            OP_LOAD, OP_STORE: begin
                legal = !f3[2];
                if (legal) begin
                    o = z; o.alu_src_a = 1; o.alu_src_b = 2; o.load_aout = 1; pending.push_back(o);
                    if (ins[6:0] == OP_LOAD) begin
                        pending.push_back(z);
                        o = z; o.load_mdr = 1; pending.push_back(o);
                        o = pc4(z); o.reg_write = 1; o.mem_to_reg = 1; o.load_splice = f3[1:0];
                        pending.push_back(o);
                    end else begin
                        o = pc4(z); o.dmem_op = 1; o.store_splice = f3[1:0]; pending.push_back(o);
                    end
                end
            end
            OP_BRANCH: begin
                legal = (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b100 || f3 == 3'b101);
                tk = (f3 == 3'b000) ? eq : (f3 == 3'b001) ? !eq : (f3 == 3'b100) ? less : !less;
                if (legal) begin
                    o = z; o.alu_src_a = 1; o.alu_op = ALU_SUB; o.pc_write_cond = 1;
                    o.pc_source = 1; o.pc_write_state = tk; pending.push_back(o);
                    if (!tk) pending.push_back(pc4(z));
                end
            end
            OP_JAL, OP_JALR: begin
                if (ins[6:0] == OP_JALR) begin
                    o = z; o.alu_src_a = 1; o.alu_src_b = 2; o.load_aout = 1; pending.push_back(o);
                end
                pending.push_back(pc4(z));
                o = z; o.reg_write = 1; o.mem_to_reg = 2; o.pc_source = 1; o.pc_write = 1;
                o.pc_write_state = 1; pending.push_back(o);
            end
            default: legal = 0;
        endcase
        if (!legal) begin
            pending_halts = 1;
            o = z; o.halted = 1;
            for (int i = 0; i < halt_cycles; i++) pending.push_back(o);
        end
    endtask

    // Assert reset (async), check outputs clear immediately, then release
    // so the next edge starts FETCH. Returns just after that edge.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("reset_clears_outputs", 32'(sample()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_holds_outputs", 32'(sample()), 32'd0);
        @(negedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Called at the start of a FETCH cycle; returns at the start of the next.
    task automatic run_instr(input logic [31:0] ins, input bit eq, input bit less, input int halt_cycles);
        int n;
        build(ins, eq, less, halt_cycles);
        n = pending.size();
        for (int i = 0; i < n; i++) sb.push_back('{pending[i], ins, i + 1});
        bus.instruction = ins;
        bus.alu_equal   = eq;
        bus.alu_less    = less;
        bus.alu_zero    = 1'($urandom);
        bus.alu_greater = 1'($urandom);
        repeat (n) @(posedge clk);
        #1;
        if (pending_halts) do_reset();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [2:0]  br_f3[6];
        int          k;
        br_f3 = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};
        r = $urandom;
        k = $urandom_range(0, 9);
        case (k)
            0: begin
                r[6:0] = OP_R;
                case ($urandom_range(0, 3))
                    0, 1: r[31:25] = 7'h00;
                    2: r[31:25] = 7'h20;
                    default: ;
                endcase
            end
            1: begin
                r[6:0] = OP_I;
                if ($urandom_range(0, 1) == 1) r[31:26] = $urandom_range(0, 1) == 1 ? 6'h10 : 6'h00;
            end
            2: r[6:0] = OP_LUI;
            3: r[6:0] = OP_LOAD;
            4: begin r[6:0] = OP_STORE; r[14] = 1'b0; end
            5: begin r[6:0] = OP_BRANCH; r[14:12] = br_f3[$urandom_range(0, 5)]; end
            6: r[6:0] = OP_JAL;
            7: begin r[6:0] = OP_JALR; r[14:12] = 3'b000; end
            8: r = ($urandom_range(0, 1) == 1) ? 32'h0010_0073 : 32'h0000_0073;
            default: begin
                if (r[6:0] inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
                                   OP_JAL, OP_JALR, OP_LUI}) r[6:0] = 7'b1111111;
            end
        endcase
        return r;
    endfunction

    // Monitor: every unreset cycle pops one expectation and compares it.
    initial begin : monitor
        sb_entry_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (sb.size() == 0) begin
                    check("scoreboard_underflow", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check($sformatf("instr %h cycle %0d", e.ins, e.cyc), 32'(sample()), 32'(e.o));
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d expectations left", sb.size());
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        n_tests         = 0;
        n_fail          = 0;
        reset           = 1'b1;
        bus.instruction = 32'h0;
        bus.alu_zero    = 1'b0;
        bus.alu_equal   = 1'b0;
        bus.alu_greater = 1'b0;
        bus.alu_less    = 1'b0;
        #1;
        check("power_on_reset_outputs", 32'(sample()), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_across_edges", 32'(sample()), 32'd0);
        @(negedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;

        // Directed cases.
        run_instr(32'h0020_81B3, 0, 0, 0);   // add x3,x1,x2
        run_instr(32'h0000_B283, 0, 0, 0);   // ld x5,0(x1)
        run_instr(32'h0020_B423, 0, 0, 0);   // sd x2,8(x1)
        run_instr(32'h0020_8463, 1, 0, 0);   // beq taken
        run_instr(32'h0020_8463, 0, 1, 0);   // beq not taken
        run_instr(32'h0100_00EF, 0, 0, 0);   // jal x1,16
        run_instr(32'h0000_8067, 0, 0, 0);   // jalr x0,0(x1)
        run_instr(32'h1234_50B7, 0, 0, 0);   // lui x1,0x12345
        run_instr(32'h4020_81B3, 0, 0, 0);   // sub
        run_instr(32'h4030_D093, 0, 0, 0);   // srai
        run_instr(32'h0020_C463, 0, 1, 0);   // blt taken
        run_instr(32'h0020_D463, 0, 1, 0);   // bge not taken
        run_instr(32'h0000_C283, 0, 0, 2);   // lbu: unsupported, halts
        run_instr(32'h0010_0073, 0, 0, 22);  // ebreak halts

        // Reset while in EX_R.
        build(32'h0020_81B3, 0, 0, 0);
        for (int i = 0; i < 4; i++) sb.push_back('{pending[i], 32'h0020_81B3, i + 1});
        bus.instruction = 32'h0020_81B3;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        do_reset();
        run_instr(32'h0020_81B3, 0, 0, 0);

        // Randomized instruction stream.
        for (int n = 0; n < 200; n++) begin
            run_instr(rand_instr(), 1'($urandom), 1'($urandom), $urandom_range(1, 4));
        end

        reset = 1'b1;
        #1;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
